mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_arbiter.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of one shared memory port.
// Each requester owns a one-deep slot; at most one access is in flight.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wr_data,
  input  logic              r0_rd_req,
  input  logic              r0_wr_req,
  output logic [DATA_W-1:0] r0_rd_data,
  output logic              r0_ack,
  output logic              r0_busy,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wr_data,
  input  logic              r1_rd_req,
  input  logic              r1_wr_req,
  output logic [DATA_W-1:0] r1_rd_data,
  output logic              r1_ack,
  output logic              r1_busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              mem_rd_req,
  output logic              mem_wr_req,
  input  logic [DATA_W-1:0] mem_rd_data,
  input  logic              mem_ack,
  input  logic              mem_busy,
  output logic              grant
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t state, state_nx;

  logic [1:0]        req, req_wr, busy;
  logic [1:0]        p_vld, p_wr, ack_q;
  logic [ADDR_W-1:0] in_addr [2];
  logic [DATA_W-1:0] in_data [2];
  logic [ADDR_W-1:0] p_addr  [2];
  logic [DATA_W-1:0] p_data  [2];
  logic [DATA_W-1:0] rd_q    [2];
  logic              prio, sel, issue, done;

  assign req        = {r1_rd_req | r1_wr_req, r0_rd_req | r0_wr_req};
  assign req_wr     = {r1_wr_req, r0_wr_req};
  assign in_addr[0] = r0_addr;
  assign in_addr[1] = r1_addr;
  assign in_data[0] = r0_wr_data;
  assign in_data[1] = r1_wr_data;

  // Busy covers the ack cycle so a re-request on that edge is dropped
  assign busy       = p_vld | ack_q;
  assign r0_busy    = busy[0];
  assign r1_busy    = busy[1];
  assign r0_ack     = ack_q[0];
  assign r1_ack     = ack_q[1];
  assign r0_rd_data = rd_q[0];
  assign r1_rd_data = rd_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (issue)   state_nx = WAIT;
      WAIT:    if (mem_ack) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    issue = 1'b0;
    done  = 1'b0;
    sel   = (&p_vld) ? prio : p_vld[1];
    case (state)
      IDLE:    issue = (|p_vld) && !mem_busy;
      WAIT:    done  = mem_ack;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_vld       <= '0;
      p_wr        <= '0;
      ack_q       <= '0;
      prio        <= 1'b0;
      grant       <= 1'b0;
      mem_rd_req  <= 1'b0;
      mem_wr_req  <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
      for (int i = 0; i < 2; i++) begin
        p_addr[i] <= '0;
        p_data[i] <= '0;
        rd_q[i]   <= '0;
      end
    end else begin
      mem_rd_req <= 1'b0;
      mem_wr_req <= 1'b0;
      ack_q      <= '0;
      for (int i = 0; i < 2; i++) begin
        if (req[i] && !busy[i]) begin
          p_vld[i]  <= 1'b1;
          p_wr[i]   <= req_wr[i];
          p_addr[i] <= in_addr[i];
          p_data[i] <= in_data[i];
        end
      end
      if (issue) begin
        mem_addr    <= p_addr[sel];
        mem_wr_data <= p_data[sel];
        mem_rd_req  <= !p_wr[sel];
        mem_wr_req  <= p_wr[sel];
        grant       <= sel;
        prio        <= !sel;
      end
      if (done) begin
        ack_q[grant] <= 1'b1;
        rd_q[grant]  <= mem_rd_data;
        p_vld[grant] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a fixed-latency memory responder.
// Each test task drives its scenario and compares against hand values.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] r0_addr = '0, r0_wr_data = '0;
  logic        r0_rd_req = 1'b0, r0_wr_req = 1'b0;
  logic [31:0] r0_rd_data;
  logic        r0_ack, r0_busy;
  logic [31:0] r1_addr = '0, r1_wr_data = '0;
  logic        r1_rd_req = 1'b0, r1_wr_req = 1'b0;
  logic [31:0] r1_rd_data;
  logic        r1_ack, r1_busy;
  logic [31:0] mem_addr, mem_wr_data;
  logic        mem_rd_req, mem_wr_req;
  logic [31:0] mem_rd_data;
  logic        mem_ack;
  logic        mem_busy = 1'b0;
  logic        grant;

  int          errors = 0;
  int          checks = 0;
  int          lat = 2;
  logic [31:0] resp = '0;

  int          n_iss = 0, n_rd = 0, n_wr = 0, n_ack0 = 0, n_ack1 = 0;
  logic [31:0] last_addr = '0, last_wd = '0;
  int          gq[$];

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .r0_addr(r0_addr), .r0_wr_data(r0_wr_data),
    .r0_rd_req(r0_rd_req), .r0_wr_req(r0_wr_req),
    .r0_rd_data(r0_rd_data), .r0_ack(r0_ack), .r0_busy(r0_busy),
    .r1_addr(r1_addr), .r1_wr_data(r1_wr_data),
    .r1_rd_req(r1_rd_req), .r1_wr_req(r1_wr_req),
    .r1_rd_data(r1_rd_data), .r1_ack(r1_ack), .r1_busy(r1_busy),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req),
    .mem_rd_data(mem_rd_data), .mem_ack(mem_ack), .mem_busy(mem_busy),
    .grant(grant)
  );

  always #5 clk = ~clk;

  // Memory responder: ack lands lat cycles after the request pulse
  initial begin
    mem_ack = 1'b0;
    mem_rd_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_rd_req || mem_wr_req) begin
        repeat (lat - 1) @(posedge clk);
        #1;
        mem_ack = 1'b1;
        mem_rd_data = resp;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (mem_rd_req || mem_wr_req) begin
      n_iss++;
      gq.push_back(int'(grant));
      last_addr = mem_addr;
      last_wd = mem_wr_data;
    end
    if (mem_rd_req) n_rd++;
    if (mem_wr_req) n_wr++;
    if (r0_ack) n_ack0++;
    if (r1_ack) n_ack1++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic pulse(input bit who, input bit rd, input bit wr,
                       input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    if (!who) begin
      r0_rd_req = rd; r0_wr_req = wr; r0_addr = a; r0_wr_data = d;
    end else begin
      r1_rd_req = rd; r1_wr_req = wr; r1_addr = a; r1_wr_data = d;
    end
    @(negedge clk);
    r0_rd_req = 1'b0; r0_wr_req = 1'b0;
    r1_rd_req = 1'b0; r1_wr_req = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!r0_busy && !r1_busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (grant !== 1'b0 || mem_rd_req !== 1'b0 || mem_wr_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl: grant=%b rd=%b wr=%b want 0 0 0",
               grant, mem_rd_req, mem_wr_req);
    end
    checks++;
    if (mem_addr !== 32'h0 || mem_wr_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_mem: addr=%h wd=%h want 0 0",
               mem_addr, mem_wr_data);
    end
    checks++;
    if ({r0_ack, r1_ack, r0_busy, r1_busy} !== 4'b0) begin
      errors++;
      $display("FAIL reset_hs: ack/busy=%b want 0000",
               {r0_ack, r1_ack, r0_busy, r1_busy});
    end
    checks++;
    if (r0_rd_data !== 32'h0 || r1_rd_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_rd: r0=%h r1=%h want 0 0", r0_rd_data, r1_rd_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_read;
    int i0, a0, a1;
    bit ok;
    i0 = n_iss; a0 = n_ack0; a1 = n_ack1;
    lat = 2; resp = 32'hDEADBEEF;
    pulse(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    checks++;
    if (r0_busy !== 1'b1) begin
      errors++;
      $display("FAIL single_busy: got %b want 1", r0_busy);
    end
    @(negedge clk);
    checks++;
    if (mem_rd_req !== 1'b1 || mem_addr !== 32'h10) begin
      errors++;
      $display("FAIL single_issue: rd=%b addr=%h want 1 10",
               mem_rd_req, mem_addr);
    end
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (r0_ack) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok || r0_busy !== 1'b1) begin
      errors++;
      $display("FAIL single_ack_busy: seen=%b busy=%b want 1 1", ok, r0_busy);
    end
    wait_idle(ok);
    checks++;
    if (!ok || n_iss - i0 != 1 || n_ack0 - a0 != 1 || n_ack1 - a1 != 0) begin
      errors++;
      $display("FAIL single_counts: iss=%0d ack0=%0d ack1=%0d want 1 1 0",
               n_iss - i0, n_ack0 - a0, n_ack1 - a1);
    end
    checks++;
    if (r0_rd_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_data: got %h want deadbeef", r0_rd_data);
    end
  endtask

  task automatic test_simultaneous;
    int base, w0;
    bit ok;
    do_reset;
    base = gq.size(); w0 = n_wr;
    resp = 32'h1234;
    @(negedge clk);
    r0_rd_req = 1'b1; r0_addr = 32'h4;
    r1_wr_req = 1'b1; r1_addr = 32'h8; r1_wr_data = 32'h55;
    @(negedge clk);
    r0_rd_req = 1'b0; r1_wr_req = 1'b0;
    wait_idle(ok);
    checks++;
    if (!ok || gq.size() - base != 2) begin
      errors++;
      $display("FAIL simul_count: issues=%0d want 2", gq.size() - base);
    end else begin
      checks++;
      if (gq[base] != 0 || gq[base+1] != 1) begin
        errors++;
        $display("FAIL simul_order: grants %0d,%0d want 0,1",
                 gq[base], gq[base+1]);
      end
    end
    checks++;
    if (n_wr - w0 != 1 || last_addr !== 32'h8 || last_wd !== 32'h55) begin
      errors++;
      $display("FAIL simul_write: wr=%0d addr=%h wd=%h want 1 8 55",
               n_wr - w0, last_addr, last_wd);
    end
    checks++;
    if (r1_rd_data !== 32'h1234 || grant !== 1'b1) begin
      errors++;
      $display("FAIL simul_r1: rd=%h grant=%b want 1234 1",
               r1_rd_data, grant);
    end
  endtask

  task automatic test_round_robin;
    int base;
    bit ok;
    do_reset;
    pulse(1'b0, 1'b1, 1'b0, 32'h60, 32'h0);
    wait_idle(ok);
    base = gq.size();
    @(negedge clk);
    r0_rd_req = 1'b1; r0_addr = 32'h64;
    r1_rd_req = 1'b1; r1_addr = 32'h68;
    @(negedge clk);
    r0_rd_req = 1'b0; r1_rd_req = 1'b0;
    wait_idle(ok);
    checks++;
    if (!ok || gq.size() - base != 2) begin
      errors++;
      $display("FAIL rr_count: issues=%0d want 2", gq.size() - base);
    end else begin
      checks++;
      if (gq[base] != 1 || gq[base+1] != 0) begin
        errors++;
        $display("FAIL rr_order: grants %0d,%0d want 1,0",
                 gq[base], gq[base+1]);
      end
    end
  endtask

  task automatic test_fairness;
    int base, d0, d1;
    bit f0, f1, ok;
    do_reset;
    base = gq.size(); d0 = 0; d1 = 0; f0 = 1'b0; f1 = 1'b0;
    @(negedge clk);
    r0_rd_req = 1'b1; r0_addr = 32'h100;
    r1_rd_req = 1'b1; r1_addr = 32'h200;
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      r0_rd_req = 1'b0; r1_rd_req = 1'b0;
      if (f0) begin r0_rd_req = 1'b1; r0_addr = 32'h100 + d0; f0 = 1'b0; end
      if (f1) begin r1_rd_req = 1'b1; r1_addr = 32'h200 + d1; f1 = 1'b0; end
      if (r0_ack) begin d0++; if (d0 < 4) f0 = 1'b1; end
      if (r1_ack) begin d1++; if (d1 < 4) f1 = 1'b1; end
      if (d0 == 4 && d1 == 4) begin ok = 1'b1; break; end
    end
    r0_rd_req = 1'b0; r1_rd_req = 1'b0;
    checks++;
    if (!ok || gq.size() - base != 8) begin
      errors++;
      $display("FAIL fair_count: done=%b issues=%0d want 1 8",
               ok, gq.size() - base);
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (gq[base+k] != k % 2) begin
          errors++;
          $display("FAIL fair_grant%0d: got %0d want %0d",
                   k, gq[base+k], k % 2);
        end
      end
    end
  endtask

  task automatic test_busy_stall;
    int bad;
    bit ok;
    @(negedge clk);
    mem_busy = 1'b1;
    pulse(1'b1, 1'b1, 1'b0, 32'h30, 32'h0);
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (mem_rd_req || mem_wr_req) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stall_quiet: req cycles=%0d want 0", bad);
    end
    mem_busy = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_rd_req !== 1'b1 || mem_addr !== 32'h30 || grant !== 1'b1) begin
      errors++;
      $display("FAIL stall_issue: rd=%b addr=%h grant=%b want 1 30 1",
               mem_rd_req, mem_addr, grant);
    end
    wait_idle(ok);
  endtask

  task automatic test_back_to_back;
    int a1;
    bit ok;
    a1 = n_ack1;
    pulse(1'b0, 1'b1, 1'b0, 32'h70, 32'h0);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (mem_ack === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    r1_rd_req = 1'b1; r1_addr = 32'h74;
    @(negedge clk);
    r1_rd_req = 1'b0;
    checks++;
    if (!ok || r0_ack !== 1'b1 || r1_busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_capture: r0_ack=%b r1_busy=%b want 1 1",
               r0_ack, r1_busy);
    end
    wait_idle(ok);
    checks++;
    if (!ok || n_ack1 - a1 != 1) begin
      errors++;
      $display("FAIL b2b_r1_ack: got %0d want 1", n_ack1 - a1);
    end
  endtask

  task automatic test_reset_mid;
    int i0, a0, a1;
    bit ok;
    i0 = n_iss; a0 = n_ack0; a1 = n_ack1;
    lat = 6;
    pulse(1'b0, 1'b1, 1'b0, 32'h40, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (n_iss - i0 != 1 || n_ack0 - a0 != 0 || n_ack1 - a1 != 0) begin
      errors++;
      $display("FAIL rstmid_ack: iss=%0d ack0=%0d ack1=%0d want 1 0 0",
               n_iss - i0, n_ack0 - a0, n_ack1 - a1);
    end
    checks++;
    if (grant !== 1'b0 || mem_addr !== 32'h0 || r0_busy !== 1'b0 ||
        r0_rd_data !== 32'h0 || r1_rd_data !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_state: g=%b a=%h b=%b d0=%h d1=%h want 0",
               grant, mem_addr, r0_busy, r0_rd_data, r1_rd_data);
    end
    lat = 2; resp = 32'hBEEF0001; a0 = n_ack0;
    pulse(1'b0, 1'b1, 1'b0, 32'h44, 32'h0);
    wait_idle(ok);
    checks++;
    if (!ok || n_ack0 - a0 != 1 || r0_rd_data !== 32'hBEEF0001) begin
      errors++;
      $display("FAIL rstmid_next: acks=%0d data=%h want 1 beef0001",
               n_ack0 - a0, r0_rd_data);
    end
  endtask

  task automatic test_duplicate;
    int i0, a0;
    bit ok;
    i0 = n_iss; a0 = n_ack0;
    pulse(1'b0, 1'b1, 1'b0, 32'h50, 32'h0);
    pulse(1'b0, 1'b1, 1'b0, 32'h54, 32'h0);
    wait_idle(ok);
    checks++;
    if (!ok || n_iss - i0 != 1 || n_ack0 - a0 != 1 || last_addr !== 32'h50) begin
      errors++;
      $display("FAIL dup: iss=%0d ack0=%0d addr=%h want 1 1 50",
               n_iss - i0, n_ack0 - a0, last_addr);
    end
  endtask

  task automatic test_rdwr_both;
    int r0c, w0c;
    bit ok;
    r0c = n_rd; w0c = n_wr;
    pulse(1'b0, 1'b1, 1'b1, 32'h20, 32'h77);
    wait_idle(ok);
    checks++;
    if (!ok || n_rd - r0c != 0 || n_wr - w0c != 1 ||
        last_addr !== 32'h20 || last_wd !== 32'h77) begin
      errors++;
      $display("FAIL rdwr: rd=%0d wr=%0d addr=%h wd=%h want 0 1 20 77",
               n_rd - r0c, n_wr - w0c, last_addr, last_wd);
    end
  endtask

  initial begin
    test_reset;
    test_single_read;
    test_simultaneous;
    test_round_robin;
    test_fairness;
    test_busy_stall;
    test_back_to_back;
    test_reset_mid;
    test_duplicate;
    test_rdwr_both;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
